// File: rtl/chrono_display_driver.sv
// -----------------------------------------------------------------------------
// chrono_display_driver
//
// Takes the chronometer's binary tenths-of-second count and shows it on a
// 4-digit, common-anode, time-multiplexed 7-segment display.
//
//   * A sequential double-dabble engine turns the binary count into 4 BCD
//     digits, one shift per clock. Counts above MAX_VALUE saturate to it and
//     raise ovf.
//   * A scan counter holds each digit lit for REFRESH clocks and then moves
//     on to the next one (0 -> 1 -> 2 -> 3 -> 0).
//   * One fixed decimal point sits on digit DP_DIGIT. Leading zeros to the
//     left of that digit are blanked. blink darkens the whole display.
//
// Ports
//   clk    in   1   system clock, all state changes on its rising edge
//   rst    in   1   synchronous, active-high reset
//   value  in  16   binary count from the chronometer controller
//   blink  in   1   1 = all digits dark (the scan and conversion keep running)
//   an     out  4   digit anodes, active-low, one-hot, bit i = digit i
//   seg    out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp     out  1   decimal point, active-low
//   busy   out  1   a BCD conversion is in progress
//   ovf    out  1   the last converted value was above MAX_VALUE
// -----------------------------------------------------------------------------
module chrono_display_driver #(
  parameter int REFRESH   = 50000,  // clocks per digit, at least 2
  parameter int DP_DIGIT  = 1,      // digit whose decimal point is lit (0 = rightmost)
  parameter int MAX_VALUE = 9999    // largest displayable count
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        blink,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy,
  output logic        ovf
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CONV   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam int             REF_W    = $clog2(REFRESH);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH - 1);

  localparam logic [15:0] MAX_V  = MAX_VALUE[15:0];
  localparam logic [1:0]  DP_SEL = DP_DIGIT[1:0];

  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [15:0] f_add3(input logic [15:0] bcd);
    logic [15:0] res;
    res = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

  // BCD digit to active-low {g,f,e,d,c,b,a} pattern.
  function automatic logic [6:0] f_seg7(input logic [3:0] digit);
    logic [6:0] res;
    case (digit)
      4'd0:    res = 7'b1000000;
      4'd1:    res = 7'b1111001;
      4'd2:    res = 7'b0100100;
      4'd3:    res = 7'b0110000;
      4'd4:    res = 7'b0011001;
      4'd5:    res = 7'b0010010;
      4'd6:    res = 7'b0000010;
      4'd7:    res = 7'b1111000;
      4'd8:    res = 7'b0000000;
      4'd9:    res = 7'b0010000;
      default: res = SEG_BLANK;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Conversion state
  // ---------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [15:0] r_last_val;   // last value accepted for conversion
  logic [15:0] r_src;        // binary bits still to be shifted into r_bcd
  logic [15:0] r_bcd;        // BCD accumulator
  logic [3:0]  r_cnt;        // shifts done so far
  logic        r_ovf_pend;   // overflow flag travelling with the conversion
  logic [15:0] r_digits;     // committed digits, digit i in [4*i +: 4]
  logic        r_busy;
  logic        r_ovf;

  logic        w_over;
  logic [15:0] w_sat;
  logic [15:0] w_bcd_adj;

  assign w_over    = (value > MAX_V);
  assign w_sat     = w_over ? MAX_V : value;
  assign w_bcd_adj = f_add3(r_bcd);

  // NOTE: sequential state is written only with non-blocking assignments, so
  // every always_ff sees register values from before the edge, whatever order
  // the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last_val <= '0;
      r_src      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_digits   <= '0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Changes that arrive while a conversion runs are not lost. The
          // comparison is made again on return to IDLE, so the latest value
          // always gets converted.
          if (value != r_last_val) begin
            r_last_val <= value;
            r_src      <= w_sat;
            r_ovf_pend <= w_over;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_CONV;
          end
        end

        ST_CONV: begin
          {r_bcd, r_src} <= {w_bcd_adj, r_src} << 1;
          r_cnt          <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) r_state <= ST_COMMIT;
        end

        ST_COMMIT: begin
          r_digits <= r_bcd;
          r_ovf    <= r_ovf_pend;
          r_busy   <= 1'b0;
          r_state  <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scan counter
  // ---------------------------------------------------------------------------
  logic [REF_W-1:0] r_ref_cnt;
  logic [1:0]       r_digit_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref_cnt   <= '0;
      r_digit_sel <= '0;
    end else if (r_ref_cnt == REF_LAST) begin
      r_ref_cnt   <= '0;
      r_digit_sel <= r_digit_sel + 2'd1;  // wraps 3 -> 0
    end else begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Digit selection and leading-zero blanking
  // ---------------------------------------------------------------------------
  logic [3:0] w_cur_digit;
  logic       w_zero3;      // digit 3 is zero
  logic       w_zero2;      // digits 3..2 are zero
  logic       w_zero1;      // digits 3..1 are zero
  logic       w_zero0;      // digits 3..0 are zero
  logic       w_zero_from_sel;
  logic       w_lz_blank;

  assign w_cur_digit = r_digits[{r_digit_sel, 2'b00} +: 4];

  assign w_zero3 = (r_digits[15:12] == 4'd0);
  assign w_zero2 = w_zero3 && (r_digits[11:8] == 4'd0);
  assign w_zero1 = w_zero2 && (r_digits[7:4]  == 4'd0);
  assign w_zero0 = w_zero1 && (r_digits[3:0]  == 4'd0);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_zero_from_sel = 1'b0;
    case (r_digit_sel)
      2'd0: w_zero_from_sel = w_zero0;
      2'd1: w_zero_from_sel = w_zero1;
      2'd2: w_zero_from_sel = w_zero2;
      2'd3: w_zero_from_sel = w_zero3;
      default: w_zero_from_sel = 1'b0;
    endcase
  end

  // Digits at or to the right of the decimal point always show their value,
  // so "0.5" reads correctly rather than ".5".
  assign w_lz_blank = (r_digit_sel > DP_SEL) && w_zero_from_sel;

  // ---------------------------------------------------------------------------
  // Registered display outputs (one cycle behind digit_sel / digits)
  // ---------------------------------------------------------------------------
  logic [3:0] r_an;
  logic [6:0] r_seg;
  logic       r_dp;

  always_ff @(posedge clk) begin
    if (rst || blink) begin
      r_an  <= 4'b1111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(4'b0001 << r_digit_sel);
      r_seg <= w_lz_blank ? SEG_BLANK : f_seg7(w_cur_digit);
      r_dp  <= (r_digit_sel == DP_SEL) ? 1'b0 : 1'b1;
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = r_dp;
  assign busy = r_busy;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_chrono_display_driver.sv
// -----------------------------------------------------------------------------
// tb_chrono_display_driver
//
// Runs directed scenarios and then randomized traffic through
// chrono_display_driver (REFRESH=4). A reference model in this file works out
// the expected outputs from the display rules using plain integer arithmetic:
// saturation, the decimal digit at each position, blanking when the number is
// below 10^position, and the conversion latency.
// -----------------------------------------------------------------------------
module tb_chrono_display_driver;

  localparam int REFRESH   = 4;
  localparam int DP_DIGIT  = 1;
  localparam int MAX_VALUE = 9999;
  localparam int LATENCY   = 17;   // capture edge to digit commit

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic        blink = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  chrono_display_driver #(
    .REFRESH  (REFRESH),
    .DP_DIGIT (DP_DIGIT),
    .MAX_VALUE(MAX_VALUE)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .value(value),
    .blink(blink),
    .an   (an),
    .seg  (seg),
    .dp   (dp),
    .busy (busy),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};
  int pw [0:3] = '{1, 10, 100, 1000};

  int  m_last, m_conv, m_shown, m_left, m_ref, m_sel;
  bit  m_conv_ovf;
  logic [3:0] e_an   = 4'hF;
  logic [6:0] e_seg  = 7'h7F;
  logic       e_dp   = 1'b1;
  logic       e_busy = 1'b0;
  logic       e_ovf  = 1'b0;

  // Pattern shown at position 'pos' for the number 'v' (0..9999).
  function automatic logic [6:0] shown_seg(input int v, input int pos);
    if (pos > DP_DIGIT && v < pw[pos]) return 7'h7F;
    return seg_tab[(v / pw[pos]) % 10];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_last = 0; m_conv = 0; m_shown = 0; m_left = 0; m_ref = 0; m_sel = 0;
      m_conv_ovf = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_busy = 1'b0; e_ovf = 1'b0;
    end else begin
      // Outputs reflect the scan position and digits from before this edge.
      if (blink) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = ~(4'b0001 << m_sel);
        e_seg = shown_seg(m_shown, m_sel);
        e_dp  = (m_sel == DP_DIGIT) ? 1'b0 : 1'b1;
      end
      if (m_ref == REFRESH - 1) begin
        m_ref = 0;
        m_sel = (m_sel + 1) % 4;
      end else begin
        m_ref = m_ref + 1;
      end
      if (m_left > 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_shown = m_conv;
          e_ovf   = m_conv_ovf;
          e_busy  = 1'b0;
        end
      end else if (int'(value) != m_last) begin
        m_last     = int'(value);
        m_conv_ovf = (int'(value) > MAX_VALUE);
        m_conv     = m_conv_ovf ? MAX_VALUE : int'(value);
        m_left     = LATENCY;
        e_busy     = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles and compare every output against the model at each
  // falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("an",   32'(an),   32'(e_an));
      check("seg",  32'(seg),  32'(e_seg));
      check("dp",   32'(dp),   32'(e_dp));
      check("busy", 32'(busy), 32'(e_busy));
      check("ovf",  32'(ovf),  32'(e_ovf));
    end
  endtask

  int busy_cycles;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_an",   32'(an),   32'hF);
    check("rst_seg",  32'(seg),  32'h7F);
    check("rst_dp",   32'(dp),   32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ovf",  32'(ovf),  32'h0);

    // 1: idle scan with value 0
    rst = 1'b0;
    step(2 * 4 * REFRESH);

    // 2: 1234, busy width measured independently of the model
    value = 16'd1234;
    busy_cycles = 0;
    for (int i = 0; i < 25; i++) begin
      step(1);
      if (busy) busy_cycles++;
    end
    check("busy_width", 32'(busy_cycles), 32'(LATENCY));
    step(2 * 4 * REFRESH);

    // 3: leading-zero blanking, then a value with no blanking
    value = 16'd5;
    step(LATENCY + 4 * REFRESH + 2);
    value = 16'd1000;
    step(LATENCY + 4 * REFRESH + 2);
    value = 16'd1005;
    step(LATENCY + 4 * REFRESH + 2);

    // 4: saturation and overflow clear
    value = 16'd12345;
    step(LATENCY + 4 * REFRESH + 2);
    check("ovf_set", 32'(ovf), 32'h1);
    value = 16'd42;
    step(LATENCY + 4 * REFRESH + 2);
    check("ovf_clr", 32'(ovf), 32'h0);

    // 5: change while converting
    value = 16'd100;
    step(LATENCY + 4);
    value = 16'd200;
    step(6);
    value = 16'd201;          // arrives mid-conversion of 200
    step(2 * LATENCY + 4 * REFRESH + 4);
    check("final_busy", 32'(busy), 32'h0);

    // 6: blink, then reset mid-conversion
    blink = 1'b1;
    step(2 * REFRESH + 1);
    blink = 1'b0;
    step(REFRESH);
    value = 16'd777;
    step(6);
    rst = 1'b1;
    step(1);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_an",   32'(an),   32'hF);
    value = 16'd0;
    step(2);
    rst = 1'b0;
    step(LATENCY + 4 * REFRESH + 2);

    // Randomized traffic
    for (int k = 0; k < 200; k++) begin
      case ($urandom % 4)
        0: value = 16'($urandom_range(0, 99));
        1: value = 16'($urandom_range(0, 9999));
        2: value = 16'($urandom_range(9990, 10010));
        default: value = 16'($urandom);
      endcase
      blink = ($urandom % 8 == 0);
      if ($urandom % 40 == 0) begin
        rst = 1'b1;
        step($urandom_range(1, 2));
        rst = 1'b0;
      end
      step($urandom_range(1, 25));
    end
    blink = 1'b0;
    step(2 * LATENCY + 4 * REFRESH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
